sa_alloc_locked_aging: RTL and testbench
========================================

# sa_alloc_locked_aging

Registered, parametrised switch allocator for the router input stage, used in place of the fixed four-direction combinational allocator. The local port is always granted. Among the NUM_PORTS non-local ports, a grant goes to the requester with the lowest destination address. A port that wins keeps the grant for as long as it keeps requesting, which holds multi-flit packets together. An optional aging mechanism stops low-priority (high-address) ports from being starved.

## Interface
- NUM_PORTS, 4: number of non-local ports; legal range 2..8. Bits 0..NUM_PORTS-1 are the non-local ports. Bit NUM_PORTS is the local port.
- ADDR_WIDTH, `ROUTER_ADDR_WIDTH: width of each per-port address field.
- AGE_WIDTH, 4: width of each per-port age counter.
- AGE_LIMIT, 8: age at which a port becomes aged. Must satisfy 1 ≤ AGE_LIMIT ≤ 2^AGE_WIDTH-1.
- clk  in  1  clock; the block has a single clock domain.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- sa_request  in  NUM_PORTS+1  per-port request.
- sa_addr  in  (NUM_PORTS+1)*ADDR_WIDTH  per-port address. Port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH]. The local field is ignored.
- sa_grant  out  NUM_PORTS+1  registered grant. Non-local bits are one-hot or zero.
- sa_locked  out  1  registered; high while a non-local owner holds the grant.
- sa_owner  out  $clog2(NUM_PORTS)  registered index of the current non-local owner. Value is 0 when sa_locked is low.

## Operation
- Local port: sa_grant[NUM_PORTS] takes the value of sa_request[NUM_PORTS] at the next clock edge. It is independent of the non-local ports.
- FSM states:
  - IDLE (sa_locked=0)
  - LOCKED (sa_locked=1, owner=o)
- Next-grant calculation, evaluated every cycle:
  - LOCKED and sa_request[o]=1: keep o (stay LOCKED). Age state has no effect.
  - Otherwise, arbitrate among the current non-local requests:
    - A winner exists: go to LOCKED with the winner as owner. This allows a zero-gap handover from an old owner to a new one.
    - No requests: go to IDLE.
- Arbitration (combinational):
  - Aged candidates are requesting ports with age ≥ AGE_LIMIT. If any exist, the lowest-index aged port wins.
  - Otherwise, the requesting port with the smallest unsigned address wins.
  - Address ties go to the lowest index.
- Aging, per non-local port i, at each edge:
  - If sa_request[i]=1 and next-grant[i]=0: age[i] increments, saturating at 2^AGE_WIDTH-1.
  - Otherwise: age[i] is cleared to 0. Age therefore clears when the port is granted and when it stops requesting.
- Addresses are compared only at arbitration time. Changes to the owner's address while LOCKED are ignored.

## Timing
- Latency is 1 cycle: a request present in cycle t appears as a grant in cycle t+1.
- Owner release: if the owner drops its request in cycle t, its grant drops in cycle t+1. In that same cycle t+1, the winner of arbitration over the requests of cycle t is granted.
- Reset values: sa_grant=0, sa_locked=0, sa_owner=0, all ages=0, state IDLE.
- Reset asserted mid-packet: all outputs clear immediately, without waiting for a clock edge. After reset is released, the first edge re-arbitrates from scratch.
- A new request from the local port never affects non-local state.

## Configuration
- SA_AGING_EN defined: age counters and aged priority are present, as described above.
- SA_AGING_EN undefined:
  - No age registers are built.
  - Arbitration is pure minimum address with lowest-index tie-break.
  - AGE_WIDTH and AGE_LIMIT are ignored.
  - Starvation is then possible, and this is accepted.

## Structure
- Shared package router_pkg holds:
  - the DIR_* index constants
  - the default ROUTER_ADDR_WIDTH
  - a function for the port-index width
- One sub-module, sa_min_addr_arb: a combinational tree that finds the minimum address with lowest-index tie-break. Its parameters are NUM_PORTS and ADDR_WIDTH. Its inputs are a request mask and the packed addresses. Its outputs are a valid flag and the winning index.
- The aged-priority selection, FSM, age counters and output registers are in the top level.

## Test plan
- Reset: hold rst_n=0 while requests are active.
  - Required: all outputs are 0 asynchronously.
  - Release reset with sa_request=5'b10000. Required: sa_grant=5'b10000 one edge later.
- Minimum address: ports 0–3 request with addresses 9, 3, 3, 7.
  - Required: one cycle later, sa_grant=5'b00010, sa_owner=1, sa_locked=1.
- Lock hold: with port 1 owning, port 2's address drops to 0.
  - Required: the grant stays on port 1 while sa_request[1]=1.
  - Drop sa_request[1] in cycle t. Required: sa_grant=5'b00100 in cycle t+1, with no idle gap.
- Release to idle: the owner drops its request and no other requests are present.
  - Required: next cycle sa_grant[3:0]=0, sa_locked=0, sa_owner=0.
- Aging (SA_AGING_EN, AGE_LIMIT=8):
  - Port 3 (address 15) requests continuously. Ports 0–2 (address 1) request repeatedly as single-cycle packets.
  - Required: port 3 is granted no later than the 9th cycle after it starts requesting. Its age then reads 0.
- Aging disabled: same stimulus without SA_AGING_EN.
  - Required: port 3 is never granted over 100 cycles.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: port direction indices, default address width,
// allocator state encoding and the port-index width helper.
package router_pkg;

    localparam int ROUTER_ADDR_WIDTH = 4;

    localparam int DIR_NORTH = 0;
    localparam int DIR_EAST  = 1;
    localparam int DIR_SOUTH = 2;
    localparam int DIR_WEST  = 3;
    localparam int DIR_LOCAL = 4;

    typedef enum logic {
        SA_ST_IDLE   = 1'b0,
        SA_ST_LOCKED = 1'b1
    } sa_state_e;

    // Width needed to hold a port index; never less than one bit.
    function automatic int port_idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/sa_min_addr_arb.sv
// Combinational minimum-address finder over a request mask; ties resolve to
// the lowest port index. Built as a balanced binary tree padded to a power of two.
module sa_min_addr_arb
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = ROUTER_ADDR_WIDTH,
    localparam int IW        = port_idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    output logic                            valid,
    output logic [IW-1:0]                   idx
);

    localparam int LEAVES = 1 << IW;
    localparam int NODES  = 2 * LEAVES - 1;

    logic                  leaf_vld  [LEAVES];
    logic [IW-1:0]         leaf_idx  [LEAVES];
    logic [ADDR_WIDTH-1:0] leaf_addr [LEAVES];

    genvar gi;
    generate
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < NUM_PORTS) begin : g_real
                assign leaf_vld[gi]  = req[gi];
                assign leaf_idx[gi]  = IW'(gi);
                assign leaf_addr[gi] = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin : g_pad
                assign leaf_vld[gi]  = 1'b0;
                assign leaf_idx[gi]  = '0;
                assign leaf_addr[gi] = '0;
            end
        end
    endgenerate

    logic                  node_vld  [NODES];
    logic [IW-1:0]         node_idx  [NODES];
    logic [ADDR_WIDTH-1:0] node_addr [NODES];

    // Node n has children 2n+1 (lower indices) and 2n+2; equal addresses keep the left child.
    always_comb begin
        node_vld  = '{default: '0};
        node_idx  = '{default: '0};
        node_addr = '{default: '0};
        for (int n = NODES - 1; n >= 0; n--) begin
            if (n >= LEAVES - 1) begin
                node_vld[n]  = leaf_vld[n-(LEAVES-1)];
                node_idx[n]  = leaf_idx[n-(LEAVES-1)];
                node_addr[n] = leaf_addr[n-(LEAVES-1)];
            end else if (node_vld[2*n+2] &&
                         (!node_vld[2*n+1] || (node_addr[2*n+2] < node_addr[2*n+1]))) begin
                node_vld[n]  = 1'b1;
                node_idx[n]  = node_idx[2*n+2];
                node_addr[n] = node_addr[2*n+2];
            end else begin
                node_vld[n]  = node_vld[2*n+1];
                node_idx[n]  = node_idx[2*n+1];
                node_addr[n] = node_addr[2*n+1];
            end
        end
    end

    assign valid = node_vld[0];
    assign idx   = node_idx[0];

endmodule

// File: rtl/sa_alloc_locked_aging.sv
// Registered switch allocator with packet locking and optional aging
// (enable aging with the SA_AGING_EN macro). The local port is always granted.
module sa_alloc_locked_aging
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = ROUTER_ADDR_WIDTH,
    parameter int AGE_WIDTH  = 4,
    parameter int AGE_LIMIT  = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS:0]                  sa_request,
    input  logic [(NUM_PORTS+1)*ADDR_WIDTH-1:0] sa_addr,
    output logic [NUM_PORTS:0]                  sa_grant,
    output logic                                sa_locked,
    output logic [$clog2(NUM_PORTS)-1:0]        sa_owner
);

    localparam int IW = port_idx_width(NUM_PORTS);

    logic [NUM_PORTS-1:0] req_nl;
    logic                 min_vld;
    logic [IW-1:0]        min_idx;
    logic                 aged_vld;
    logic [IW-1:0]        aged_idx;

    sa_state_e            state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [NUM_PORTS:0]   grant_q, grant_d;

    logic                 unused_local_addr;

    assign req_nl            = sa_request[NUM_PORTS-1:0];
    assign unused_local_addr = ^sa_addr[NUM_PORTS*ADDR_WIDTH +: ADDR_WIDTH];

    sa_min_addr_arb #(
        .NUM_PORTS  (NUM_PORTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_min_arb (
        .req   (req_nl),
        .addr  (sa_addr[NUM_PORTS*ADDR_WIDTH-1:0]),
        .valid (min_vld),
        .idx   (min_idx)
    );

`ifdef SA_AGING_EN
    logic [NUM_PORTS-1:0][AGE_WIDTH-1:0] age_q, age_d;
    logic [NUM_PORTS-1:0]                aged_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_aged
            assign aged_mask[gi] = req_nl[gi] && (age_q[gi] >= AGE_WIDTH'(AGE_LIMIT));
        end
    endgenerate

    always_comb begin
        aged_vld = |aged_mask;
        aged_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (aged_mask[i]) aged_idx = IW'(i);
        end
    end

    // A port ages only while it asks and is refused in the coming cycle.
    always_comb begin
        age_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_nl[i] && !grant_d[i]) begin
                age_d[i] = (age_q[i] == {AGE_WIDTH{1'b1}}) ? age_q[i] : age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_d;
    end
`else
    localparam int unused_age_cfg = AGE_WIDTH + AGE_LIMIT;

    assign aged_vld = 1'b0;
    assign aged_idx = '0;
`endif

    // A live owner keeps the grant regardless of age; otherwise re-arbitrate,
    // which also gives a zero-gap handover when the owner lets go.
    always_comb begin
        state_d = SA_ST_IDLE;
        owner_d = '0;
        if ((state_q == SA_ST_LOCKED) && req_nl[owner_q]) begin
            state_d = SA_ST_LOCKED;
            owner_d = owner_q;
        end else if (min_vld) begin
            state_d = SA_ST_LOCKED;
            owner_d = aged_vld ? aged_idx : min_idx;
        end

        grant_d            = '0;
        grant_d[NUM_PORTS] = sa_request[NUM_PORTS];
        if (state_d == SA_ST_LOCKED) grant_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SA_ST_IDLE;
            owner_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
        end
    end

    assign sa_grant  = grant_q;
    assign sa_locked = (state_q == SA_ST_LOCKED);
    assign sa_owner  = owner_q;

endmodule

// File: tb/tb_sa_alloc_locked_aging.sv
// Randomised and directed bench for sa_alloc_locked_aging against a
// behavioural allocator model; honours SA_AGING_EN like the design.
module tb_sa_alloc_locked_aging;
    import router_pkg::*;

    localparam int NP      = 4;
    localparam int AW      = ROUTER_ADDR_WIDTH;
    localparam int AGE_W   = 4;
    localparam int AGE_LIM = 8;
    localparam int AGE_MAX = (1 << AGE_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NP:0]            sa_request = '0;
    logic [(NP+1)*AW-1:0]   sa_addr = '0;
    logic [NP:0]            sa_grant;
    logic                   sa_locked;
    logic [$clog2(NP)-1:0]  sa_owner;

    sa_alloc_locked_aging #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .AGE_WIDTH  (AGE_W),
        .AGE_LIMIT  (AGE_LIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sa_request (sa_request),
        .sa_addr    (sa_addr),
        .sa_grant   (sa_grant),
        .sa_locked  (sa_locked),
        .sa_owner   (sa_owner)
    );

    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int n_txn         = 0;

    // Reference model state
    int m_owner;
    int m_local;
    int m_age [NP];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_local = 0;
        for (int i = 0; i < NP; i++) m_age[i] = 0;
    endtask

    function automatic int addr_of(input logic [(NP+1)*AW-1:0] a, input int p);
        return int'(a[p*AW +: AW]);
    endfunction

    // One clock edge of the allocator rules, computed on plain integers.
    task automatic model_edge(input logic [NP:0] req, input logic [(NP+1)*AW-1:0] a);
        int nxt;
        int best;
        nxt = -1;
        if (m_owner >= 0 && req[m_owner]) begin
            nxt = m_owner;
        end else begin
`ifdef SA_AGING_EN
            for (int i = 0; i < NP; i++)
                if (nxt < 0 && req[i] && m_age[i] >= AGE_LIM) nxt = i;
`endif
            if (nxt < 0) begin
                best = -1;
                for (int i = 0; i < NP; i++)
                    if (req[i] && (best < 0 || addr_of(a, i) < addr_of(a, best))) best = i;
                nxt = best;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (req[i] && i != nxt) m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
            else                    m_age[i] = 0;
        end
        m_owner = nxt;
        m_local = int'(req[NP]);
    endtask

    function automatic logic [31:0] exp_grant();
        logic [31:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        g[NP] = m_local[0];
        return g;
    endfunction

    task automatic check_model(input string tag);
        check_eq({tag, "_grant"},  32'(sa_grant),  exp_grant());
        check_eq({tag, "_locked"}, 32'(sa_locked), (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq({tag, "_owner"},  32'(sa_owner),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    endtask

    // Apply one cycle of inputs, advance the model and the DUT, then compare.
    task automatic step(input logic [NP:0] req, input string tag);
        sa_request = req;
        model_edge(req, sa_addr);
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d %s req=%b addr=%h grant=%b locked=%0d owner=%0d",
                 n_txn, tag, req, sa_addr, sa_grant, sa_locked, sa_owner);
        check_model(tag);
    endtask

    task automatic set_addrs(input int a0, input int a1, input int a2, input int a3);
        logic [31:0] v;
        v = 32'(a0); sa_addr[0*AW +: AW] = v[AW-1:0];
        v = 32'(a1); sa_addr[1*AW +: AW] = v[AW-1:0];
        v = 32'(a2); sa_addr[2*AW +: AW] = v[AW-1:0];
        v = 32'(a3); sa_addr[3*AW +: AW] = v[AW-1:0];
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"},  32'(sa_grant),  32'd0);
        check_eq({tag, "_locked"}, 32'(sa_locked), 32'd0);
        check_eq({tag, "_owner"},  32'(sa_owner),  32'd0);
    endtask

    initial begin
        int first_g3;
        logic [NP:0] r;

        model_reset();
        // Reset held with every port requesting
        sa_request = '1;
        set_addrs(2, 5, 1, 9);
        #3;
        check_all_zero("rst_hold");
        @(posedge clk); @(posedge clk);
        #2;
        check_all_zero("rst_hold_edges");

        sa_request = 5'b10000;
        rst_n = 1'b1;
        step(5'b10000, "rst_release_local");
        check_eq("local_after_reset", 32'(sa_grant), 32'b10000);

        // Minimum address with a tie between ports 1 and 2
        set_addrs(9, 3, 3, 7);
        step(5'b01111, "min_addr");
        check_eq("min_addr_grant", 32'(sa_grant), 32'b00010);
        check_eq("min_addr_owner", 32'(sa_owner), 32'd1);

        // Lock hold while a competitor becomes cheaper
        set_addrs(9, 3, 0, 7);
        step(5'b01111, "lock_hold");
        step(5'b01111, "lock_hold");
        check_eq("lock_hold_grant", 32'(sa_grant), 32'b00010);
        step(5'b01101, "handover");
        check_eq("handover_grant", 32'(sa_grant), 32'b00100);

        step(5'b00000, "release_idle");
        check_all_zero("release_idle_direct");

        // Reset asserted mid-packet
        set_addrs(9, 3, 0, 7);
        step(5'b10101, "pre_reset");
        step(5'b10101, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_edge");
        rst_n = 1'b1;
        step(5'b10000, "post_reset");
        step(5'b00000, "idle");

        // Starvation pattern: port 3 far away, ports 0..2 close as one-cycle packets
        set_addrs(1, 1, 1, 15);
        first_g3 = -1;
        for (int k = 1; k <= 100; k++) begin
            r = '0;
            r[3] = 1'b1;
            r[(k - 1) % 3] = 1'b1;
            step(r, "starve");
            if (first_g3 < 0 && sa_grant[3]) begin
                first_g3 = k;
`ifdef SA_AGING_EN
                check_eq("aged_age_cleared", 32'(dut.age_q[3]), 32'(m_age[3]));
`endif
            end
`ifndef SA_AGING_EN
            check_eq("starve_no_grant3", 32'(sa_grant[3]), 32'd0);
`endif
        end
`ifdef SA_AGING_EN
        check_eq("aged_grant_by_9", (first_g3 > 0 && first_g3 <= 9) ? 32'd1 : 32'd0, 32'd1);
`endif
        step(5'b00000, "idle");

        // Random traffic with bursts that hold requests to exercise locking
        r = '0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) r = NP'($urandom_range(0, 31)) | {($urandom_range(0, 1) == 1), {NP{1'b0}}};
            else                          r[$urandom_range(0, NP)] = ~r[$urandom_range(0, NP)];
            if ($urandom_range(0, 3) == 0) sa_addr = (NP+1)*AW'($urandom);
            if ($urandom_range(0, 7) == 0) sa_addr[0 +: AW] = sa_addr[AW +: AW];
            step(r, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
